// File: rtl/silencer_pkg.sv
// Shared types and sizing constants for the silencer rate limiter.
package silencer_pkg;

    localparam int WIDTH_DEF     = 13;
    localparam int TRANS_NUM_DEF = 249;
    localparam int IDX_W         = $clog2(TRANS_NUM_DEF);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/silencer_step.sv
// Single-channel step: moves duty linearly and phase along the shortest circular path,
// each by at most STEP.
module silencer_step #(
    parameter int WIDTH = 13
) (
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] cycle,
    input  logic [WIDTH-1:0] tgt_duty,
    input  logic [WIDTH-1:0] cur_duty,
    input  logic [WIDTH-1:0] tgt_phase,
    input  logic [WIDTH-1:0] cur_phase,
    output logic [WIDTH-1:0] next_duty,
    output logic [WIDTH-1:0] next_phase
);

    localparam int EW = WIDTH + 1;

    function automatic logic [EW-1:0] umin(input logic [EW-1:0] a, input logic [EW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    logic signed [EW-1:0] d_diff;
    logic signed [EW-1:0] d_mag;
    logic [EW-1:0] step_e, cyc_e, tp_e, cp_e;
    logic [EW-1:0] fwd, bwd, half, mv_f, mv_b, sum_f, wrap_f, diff_b;

    always_comb begin
        step_e = {1'b0, step};
        cyc_e  = {1'b0, cycle};
        tp_e   = {1'b0, tgt_phase};
        cp_e   = {1'b0, cur_phase};

        d_diff = signed'({1'b0, tgt_duty}) - signed'({1'b0, cur_duty});
        d_mag  = d_diff[EW-1] ? -d_diff : d_diff;

        // Forward distance around the circle; backward is its complement.
        fwd    = (tp_e >= cp_e) ? (tp_e - cp_e) : (tp_e + cyc_e - cp_e);
        bwd    = cyc_e - fwd;
        half   = cyc_e >> 1;
        mv_f   = umin(step_e, fwd);
        mv_b   = umin(step_e, bwd);
        sum_f  = cp_e + mv_f;
        wrap_f = (sum_f >= cyc_e) ? (sum_f - cyc_e) : sum_f;
        diff_b = (cp_e >= mv_b) ? (cp_e - mv_b) : (cp_e + cyc_e - mv_b);

        next_duty  = cur_duty;
        next_phase = cur_phase;
        if (cycle == '0) begin
            next_duty  = '0;
            next_phase = '0;
        end else if (step == '0) begin
            next_duty  = tgt_duty;
            next_phase = tgt_phase;
        end else begin
            if ($unsigned(d_mag) <= step_e)
                next_duty = tgt_duty;
            else if (!d_diff[EW-1])
                next_duty = cur_duty + step;
            else
                next_duty = cur_duty - step;

            if (cp_e >= cyc_e)
                next_phase = tgt_phase;
            else if (fwd == '0)
                next_phase = cur_phase;
            else if (fwd <= half)
                next_phase = wrap_f[WIDTH-1:0];
            else
                next_phase = diff_b[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/silencer.sv
// Sweeps every transducer channel once per pass, rate-limiting duty/phase outputs
// through a two-stage pipe (fetch, then step-and-write).
module silencer
    import silencer_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int TRANS_NUM = TRANS_NUM_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             update,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] cycle     [TRANS_NUM],
    input  logic [WIDTH-1:0] duty_in   [TRANS_NUM],
    input  logic [WIDTH-1:0] phase_in  [TRANS_NUM],
    output logic [WIDTH-1:0] duty_out  [TRANS_NUM],
    output logic [WIDTH-1:0] phase_out [TRANS_NUM],
    output logic             busy,
    output logic             done
);

    localparam int IW = $clog2(TRANS_NUM);
    localparam int CW = $clog2(TRANS_NUM + 2);
    localparam logic [CW-1:0] NUM_C = CW'(TRANS_NUM);
    localparam logic [CW-1:0] FIN_C = CW'(TRANS_NUM + 1);

    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic pending;
    logic [WIDTH-1:0] step_q;
    logic start, issue, finish;

    logic vld_p1;
    logic [IW-1:0] idx_p1;
    logic [WIDTH-1:0] cyc_p1, tgt_duty_p1, cur_duty_p1, tgt_phase_p1, cur_phase_p1;
    logic [WIDTH-1:0] next_duty, next_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start)  state_nx = RUN;
            RUN:     if (finish) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // A pass ends one cycle after the last channel write drains out of stage 2.
    always_comb begin
        start  = (state == IDLE) && (update || pending);
        issue  = (state == RUN) && (cnt < NUM_C);
        finish = (state == RUN) && (cnt == FIN_C);
        busy   = (state == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            pending <= 1'b0;
            step_q  <= '0;
            done    <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            done   <= finish;
            vld_p1 <= issue;
            if (start) begin
                cnt     <= '0;
                step_q  <= step;
                pending <= 1'b0;
            end else if (state == RUN) begin
                cnt <= cnt + 1'b1;
                if (update) pending <= 1'b1;
            end
        end
    end

    // Stage 1: fetch live target and current value for channel cnt.
    always_ff @(posedge clk) begin
        if (issue) begin
            idx_p1       <= cnt[IW-1:0];
            cyc_p1       <= cycle[cnt[IW-1:0]];
            tgt_duty_p1  <= duty_in[cnt[IW-1:0]];
            cur_duty_p1  <= duty_out[cnt[IW-1:0]];
            tgt_phase_p1 <= phase_in[cnt[IW-1:0]];
            cur_phase_p1 <= phase_out[cnt[IW-1:0]];
        end
    end

    silencer_step #(.WIDTH(WIDTH)) u_step (
        .step       (step_q),
        .cycle      (cyc_p1),
        .tgt_duty   (tgt_duty_p1),
        .cur_duty   (cur_duty_p1),
        .tgt_phase  (tgt_phase_p1),
        .cur_phase  (cur_phase_p1),
        .next_duty  (next_duty),
        .next_phase (next_phase)
    );

    // Stage 2: write the stepped values back to channel idx_p1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TRANS_NUM; i++) begin
                duty_out[i]  <= '0;
                phase_out[i] <= '0;
            end
        end else if (vld_p1) begin
            duty_out[idx_p1]  <= next_duty;
            phase_out[idx_p1] <= next_phase;
        end
    end

endmodule

// File: tb/tb_silencer.sv
// Randomized bench for silencer with a pass-level reference model and literal anchors.
module tb_silencer;

    localparam int W = 13;
    localparam int N = 249;

    logic clk = 1'b0;
    logic rst_n;
    logic update;
    logic [W-1:0] step;
    logic [W-1:0] cycle     [N];
    logic [W-1:0] duty_in   [N];
    logic [W-1:0] phase_in  [N];
    logic [W-1:0] duty_out  [N];
    logic [W-1:0] phase_out [N];
    logic busy, done;

    int vectors = 0;
    int miscompares = 0;

    int m_duty[N], m_phase[N], n_duty[N], n_phase[N];
    int k = 0;
    int start_k = 0, done_k = 0;
    bit m_busy = 0, m_pend = 0, exp_done = 0;

    always #5 clk = ~clk;

    silencer #(.WIDTH(W), .TRANS_NUM(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .update    (update),
        .step      (step),
        .cycle     (cycle),
        .duty_in   (duty_in),
        .phase_in  (phase_in),
        .duty_out  (duty_out),
        .phase_out (phase_out),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Reference rules for one channel, in plain integer arithmetic.
    function automatic void model_step(input int td, input int cd, input int tp, input int cp,
                                       input int cyc, input int st, output int nd, output int np);
        int f;
        if (cyc == 0) begin
            nd = 0; np = 0;
        end else if (st == 0) begin
            nd = td; np = tp;
        end else begin
            if ((td - cd <= st) && (cd - td <= st)) nd = td;
            else if (td > cd) nd = cd + st;
            else nd = cd - st;
            if (cp >= cyc) np = tp;
            else begin
                f = (((tp - cp) % cyc) + cyc) % cyc;
                if (f == 0) np = cp;
                else if (f <= cyc / 2) np = (cp + imin(st, f)) % cyc;
                else np = (((cp - imin(st, cyc - f)) % cyc) + cyc) % cyc;
            end
        end
    endfunction

    // Pass-level model: a request starts a pass, results land N+2 edges later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_duty[i] = 0; m_phase[i] = 0;
            end
            m_busy = 0; m_pend = 0; exp_done = 0;
        end else begin
            k++;
            if (m_busy) begin
                if (update) m_pend = 1;
                if (k == done_k) begin
                    m_busy = 0;
                    exp_done = 1;
                    m_duty = n_duty;
                    m_phase = n_phase;
                end
            end else begin
                exp_done = 0;
                if (update || m_pend) begin
                    m_pend = 0;
                    m_busy = 1;
                    start_k = k;
                    done_k = k + N + 2;
                    for (int i = 0; i < N; i++)
                        model_step(int'(duty_in[i]), m_duty[i], int'(phase_in[i]), m_phase[i],
                                   int'(cycle[i]), int'(step), n_duty[i], n_phase[i]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            int j;
            chk("busy", int'(busy), int'(m_busy));
            chk("done", int'(done), int'(exp_done));
            if (m_busy) begin
                j = k - start_k - 2;
                if (j >= 0 && j < N) begin
                    chk($sformatf("duty_wr[%0d]", j), int'(duty_out[j]), n_duty[j]);
                    chk($sformatf("phase_wr[%0d]", j), int'(phase_out[j]), n_phase[j]);
                    if (j + 1 < N)
                        chk($sformatf("duty_old[%0d]", j + 1), int'(duty_out[j + 1]), m_duty[j + 1]);
                end
            end
            if (exp_done) begin
                for (int i = 0; i < N; i++) begin
                    chk($sformatf("duty[%0d]", i), int'(duty_out[i]), m_duty[i]);
                    chk($sformatf("phase[%0d]", i), int'(phase_out[i]), m_phase[i]);
                end
            end
        end
    end

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int c = 0; c < N + 10; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        chk("pass_timeout", int'(seen), 1);
    endtask

    // One pass; optionally re-request exactly in the DONE cycle.
    task automatic run_pass(input bit coincide);
        @(negedge clk);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        wait_done();
        if (coincide) begin
            update = 1'b1;
            @(negedge clk);
            update = 1'b0;
            wait_done();
        end
    endtask

    task automatic set_all(input int cyc, input int d, input int p);
        for (int i = 0; i < N; i++) begin
            cycle[i] = W'(cyc); duty_in[i] = W'(d); phase_in[i] = W'(p);
        end
    endtask

    task automatic randomize_inputs();
        int cyc, sel;
        for (int i = 0; i < N; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) cyc = 0;
            else if (sel < 4) cyc = 4096;
            else if (sel < 6) cyc = 2000;
            else cyc = $urandom_range(1, 8191);
            cycle[i] = W'(cyc);
            duty_in[i] = W'($urandom_range(0, 8191));
            phase_in[i] = (cyc == 0) ? W'($urandom_range(0, 8191)) : W'($urandom_range(0, cyc - 1));
        end
        sel = $urandom_range(0, 4);
        if (sel == 0) step = '0;
        else if (sel < 4) step = W'($urandom_range(1, 600));
        else step = W'($urandom_range(1, 8191));
    endtask

    initial begin
        int first_done, second_done, done_cnt;
        bit all_zero;
        rst_n = 1'b0;
        update = 1'b0;
        step = '0;
        set_all(4096, 0, 0);
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_duty0", int'(duty_out[0]), 0);
        #2 rst_n = 1'b1;

        // Duty ramp toward 2048 in steps of 100.
        set_all(4096, 2048, 0);
        step = W'(100);
        for (int p = 1; p <= 22; p++) begin
            run_pass(0);
            if (p == 1)  chk("ramp_p1", int'(duty_out[0]), 100);
            if (p == 20) chk("ramp_p20", int'(duty_out[200]), 2000);
            if (p == 21) chk("ramp_p21", int'(duty_out[0]), 2048);
            if (p == 22) chk("ramp_p22", int'(duty_out[248]), 2048);
        end

        // Phase shortest-path, tie, and cycle-change snap.
        phase_in[5] = W'(100); phase_in[7] = W'(0); phase_in[9] = W'(3000);
        step = '0;
        run_pass(0);
        chk("bypass_ch5", int'(phase_out[5]), 100);
        chk("bypass_ch9", int'(phase_out[9]), 3000);
        phase_in[5] = W'(4000); phase_in[7] = W'(2048);
        cycle[9] = W'(2000); phase_in[9] = W'(500);
        step = W'(64);
        run_pass(0);
        chk("phase_p1", int'(phase_out[5]), 36);
        chk("tie_fwd", int'(phase_out[7]), 64);
        chk("snap_ch9", int'(phase_out[9]), 500);
        run_pass(0);
        chk("phase_p2", int'(phase_out[5]), 4068);
        run_pass(0);
        chk("phase_p3", int'(phase_out[5]), 4004);
        run_pass(0);
        chk("phase_p4", int'(phase_out[5]), 4000);
        phase_in[7] = W'(0); step = '0;
        run_pass(0);
        phase_in[7] = W'(2048);
        run_pass(0);
        chk("step0_tie", int'(phase_out[7]), 2048);

        // Repeated requests during a pass collapse into a single follow-up pass.
        first_done = -1; second_done = -1; done_cnt = 0;
        step = W'(37);
        set_all(4096, 1000, 3000);
        @(negedge clk);
        update = 1'b1;
        for (int m = 1; m <= 2 * N + 20; m++) begin
            @(negedge clk);
            update = (m == 10 || m == 50 || m == 100);
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) first_done = m;
                if (done_cnt == 2) second_done = m;
            end
        end
        update = 1'b0;
        chk("done_count", done_cnt, 2);
        chk("first_done_at", first_done, N + 3);
        chk("second_done_at", second_done, 2 * N + 6);

        // Randomized passes, some re-requested in the DONE cycle.
        for (int r = 0; r < 16; r++) begin
            randomize_inputs();
            run_pass($urandom_range(0, 2) == 0);
        end

        // Reset mid-pass around index 100.
        @(negedge clk);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        repeat (100) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        all_zero = 1;
        for (int i = 0; i < N; i++)
            if (duty_out[i] != '0 || phase_out[i] != '0) all_zero = 0;
        chk("midreset_outputs_zero", int'(all_zero), 1);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_done", int'(done), 0);
        @(negedge clk);
        chk("midreset_done_held", int'(done), 0);
        #2 rst_n = 1'b1;
        randomize_inputs();
        run_pass(0);
        randomize_inputs();
        run_pass(0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
